mem_port_arbiter: RTL

//  Shares the single-port unified memory between the IF stage (instruction fetch) and the M stage (load/store).

---
 rtl/folio_mem_pkg.sv | 29 ++
 rtl/arb_starve_ctr.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/folio_mem_pkg.sv
// ---------------------------------------------------------------------------
// folio_mem_pkg
// Shared definitions for the unified-memory port arbiter and its helpers.
//   - ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   - OP_LOAD / OP_STORE      : M-stage opcodes (instr[15:12]) that raise dm_req
//   - arb_state_t             : arbiter FSM states
//   - opcode_of()             : extracts the opcode field from an instruction
// ---------------------------------------------------------------------------
package folio_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [3:0] OP_LOAD  = 4'hC;
  localparam logic [3:0] OP_STORE = 4'hD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  // The opcode lives in the top nibble of every 16-bit instruction.
  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// ---------------------------------------------------------------------------
// arb_starve_ctr
// Counts consecutive data grants that were made while a fetch was waiting,
// saturating at STARVE_MAX. Once saturated with the fetch still waiting,
// force_fetch_o tells the arbiter to hand the next grant to the fetch.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk_i          clock
//   reset_i        synchronous active-high reset
//   if_req_i       fetch request pending
//   data_grant_i   arbiter is granting a data access this cycle
//   fetch_grant_i  arbiter is granting a fetch this cycle
//   force_fetch_o  fetch must win the next grant
// ---------------------------------------------------------------------------
module arb_starve_ctr
  import folio_mem_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic if_req_i,
  input  logic data_grant_i,
  input  logic fetch_grant_i,
  output logic force_fetch_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] count_q;

  // The count only means something while a fetch is actually waiting, so a
  // dropped if_req or a served fetch both start the window over. Saturation
  // keeps the force condition asserted until the fetch is granted.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (!if_req_i || fetch_grant_i) begin
      count_q <= '0;
    end else if (data_grant_i && (count_q != CW'(STARVE_MAX))) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign force_fetch_o = if_req_i && (count_q == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-port unified memory between instruction fetch (IF) and
// load/store (M). Each access is a req/ack handshake to memory; read data and
// a one-cycle valid pulse return to the requester. Data accesses win in IDLE
// because the M-stage instruction is older.
// Optional build macro: ARB_STARVE_GUARD_EN -- after STARVE_MAX back-to-back
// data grants with a fetch waiting, the fetch wins the next grant.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   if_req_i/if_addr_i             fetch request and PC
//   if_rdata_o/if_valid_o          fetched instruction, completion pulse
//   flush_i                        discard the in-flight / pending fetch
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i   data request (load/store)
//   dm_rdata_o/dm_valid_o          load data, completion pulse
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o   memory request side
//   mem_rdata_i/mem_ack_i          memory response side
//   if_stall_o/m_stall_o           stalls to the hazard unit
// Requesters drop req in the cycle their valid pulses (or keep it high to
// issue a fresh access); the IDLE cycle that carries a valid pulse is also a
// grant cycle, which is what allows back-to-back accesses.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import folio_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              flush_i,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              if_stall_o,
  output logic              m_stall_o
);

  if (STARVE_MAX < 1) begin : g_starve_max_check
    $error("STARVE_MAX must be at least 1");
  end

  arb_state_t        state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              if_valid_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              dm_valid_q;

  logic force_fetch;
  logic fetch_ok;
  logic grant_data;
  logic grant_fetch;

  // Grant decision for the IDLE state. A flush in the same cycle suppresses
  // the fetch grant but still lets a pending data access through; the
  // starvation guard can only override data priority when a fetch could
  // actually be granted this cycle.
  always_comb begin
    fetch_ok    = if_req_i && !flush_i;
    grant_data  = dm_req_i && !(force_fetch && fetch_ok);
    grant_fetch = fetch_ok && !grant_data;
  end

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .if_req_i      (if_req_i),
    .data_grant_i  ((state_q == IDLE) && grant_data),
    .fetch_grant_i ((state_q == IDLE) && grant_fetch),
    .force_fetch_o (force_fetch)
  );
`else
  assign force_fetch = 1'b0;
`endif

  // Arbiter FSM with registered memory-side and requester-side outputs.
  // Valid pulses default low every cycle so each grant yields exactly one.
  // A flush during FETCH moves to DRAIN rather than dropping mem_req, since
  // the memory is entitled to finish the access it already accepted; a
  // flush on the very cycle of the ack simply throws the data away.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
      dm_valid_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            state_q     <= DATA;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we_i;
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
          end else if (grant_fetch) begin
            state_q    <= FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr_i;
          end
        end
        FETCH: begin
          if (mem_ack_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            if (!flush_i) begin
              if_rdata_q <= mem_rdata_i;
              if_valid_q <= 1'b1;
            end
          end else if (flush_i) begin
            state_q <= DRAIN;
          end
        end
        DATA: begin
          if (mem_ack_i) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            dm_valid_q <= 1'b1;
            if (!mem_we_q) begin
              dm_rdata_q <= mem_rdata_i;
            end
          end
        end
        DRAIN: begin
          if (mem_ack_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_valid_o  = dm_valid_q;

  assign if_stall_o = if_req_i && !if_valid_q;
  assign m_stall_o  = dm_req_i && !dm_valid_q;

endmodule
